// File: rtl/alu32_logic_seq.sv
// alu32_logic_seq: issues one logic op to the gate-level unit bank and captures its result.
// Latency: Out_Valid rises SETTLE edges after accept; minimum issue interval is SETTLE+2 cycles.
// Backpressure: result is held in HOLD until Out_Ready; In_Ready is low whenever the sequencer is busy.
module alu32_logic_seq #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2    // legal range 1..15
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [1:0]       In_Op,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    output logic [WIDTH-1:0] Unit_In1,
    output logic [WIDTH-1:0] Unit_In2,
    output logic [3:0]       Unit_En,
    input  logic [WIDTH-1:0] Unit_Res,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_Res,
    output logic             Out_Zero,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Counter value seen on the capture edge; the counter restarts at 0 on accept.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;

    // State register; reset returns to IDLE without waiting for a clock edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        Out_Valid = 1'b0;
        Busy      = 1'b1;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                In_Ready = 1'b1;
                Busy     = 1'b0;
                if (In_Valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                Out_Valid = 1'b1;
                if (Out_Ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand buses, one-hot enable and settle counter; operands persist until the next accept.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Unit_In1 <= '0;
            Unit_In2 <= '0;
            Unit_En  <= '0;
            cnt      <= '0;
        end else if (accept) begin
            Unit_In1 <= In_A;
            Unit_In2 <= In_B;
            Unit_En  <= 4'b0001 << In_Op;
            cnt      <= '0;
        end else if (capture) begin
            Unit_En  <= '0;
        end else if (state == ISSUE) begin
            cnt      <= cnt + 4'd1;
        end
    end

    // Result capture; the unit bank already produces the final value, only the zero flag is derived.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Out_Res  <= '0;
            Out_Zero <= 1'b1;
        end else if (capture) begin
            Out_Res  <= Unit_Res;
            Out_Zero <= ~|Unit_Res;
        end
    end

endmodule

// File: tb/tb_alu32_logic_seq.sv
// tb_alu32_logic_seq: directed and random ops on a SETTLE=2 and a SETTLE=1 sequencer.
// Latency: expectations are counted in clock edges from each accept.
// Backpressure: Out_Ready is held low for a chosen number of cycles per op.
module tb_alu32_logic_seq;

    logic        Clk;
    logic        Rst;
    logic        in_valid;
    logic        cur_sel;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;

    logic        iv0, iv1;
    logic        rdy0, rdy1, ov0, ov1, oz0, oz1, busy0, busy1;
    logic [31:0] in1_0, in2_0, in1_1, in2_1, ures0, ures1, ores0, ores1;
    logic [3:0]  en0, en1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc0[$];

    assign iv0 = in_valid & ~cur_sel;
    assign iv1 = in_valid & cur_sel;

    // Environment model of the enable-gated unit bank: disabled units drive 0, outputs ORed.
    function automatic logic [31:0] bank(input logic [3:0] en, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        r = '0;
        if (en[0]) r = r | (x & y);
        if (en[1]) r = r | (x | y);
        if (en[2]) r = r | (x ^ y);
        if (en[3]) r = r | ~(x | y);
        return r;
    endfunction

    assign ures0 = bank(en0, in1_0, in2_0);
    assign ures1 = bank(en1, in1_1, in2_1);

    alu32_logic_seq #(.WIDTH(32), .SETTLE(2)) u_dut2 (
        .Clk(Clk), .Rst(Rst), .In_Valid(iv0), .In_Ready(rdy0), .In_Op(in_op),
        .In_A(in_a), .In_B(in_b), .Unit_In1(in1_0), .Unit_In2(in2_0), .Unit_En(en0),
        .Unit_Res(ures0), .Out_Valid(ov0), .Out_Ready(out_ready), .Out_Res(ores0),
        .Out_Zero(oz0), .Busy(busy0)
    );

    alu32_logic_seq #(.WIDTH(32), .SETTLE(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .In_Valid(iv1), .In_Ready(rdy1), .In_Op(in_op),
        .In_A(in_a), .In_B(in_b), .Unit_In1(in1_1), .Unit_In2(in2_1), .Unit_En(en1),
        .Unit_Res(ures1), .Out_Valid(ov1), .Out_Ready(out_ready), .Out_Res(ores1),
        .Out_Zero(oz1), .Busy(busy1)
    );

    // Observation muxed to the instance under test.
    logic        o_rdy, o_ov, o_oz, o_busy;
    logic [31:0] o_in1, o_in2, o_res;
    logic [3:0]  o_en;
    assign o_rdy  = cur_sel ? rdy1  : rdy0;
    assign o_ov   = cur_sel ? ov1   : ov0;
    assign o_oz   = cur_sel ? oz1   : oz0;
    assign o_busy = cur_sel ? busy1 : busy0;
    assign o_in1  = cur_sel ? in1_1 : in1_0;
    assign o_in2  = cur_sel ? in2_1 : in2_0;
    assign o_res  = cur_sel ? ores1 : ores0;
    assign o_en   = cur_sel ? en1   : en0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Cycle count and accept log for the SETTLE=2 instance.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (!Rst && iv0 && rdy0) acc0.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: the logic function selected by the opcode.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // One full transaction: accept, settle, hold for 'hold' cycles of backpressure, handshake.
    task automatic do_op(input bit sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit pulse, input bit keep);
        int          s;
        logic [31:0] exp;
        logic [3:0]  oh;
        s   = sel ? 1 : 2;
        exp = ref_result(op, a, b);
        oh  = 4'd0;
        oh[op] = 1'b1;
        cur_sel   = sel;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        #1;
        check("in_ready_idle", o_rdy, 1);
        step();                               // accept edge E
        in_valid = keep;
        for (int k = 0; k < s; k++) begin
            if (k > 0) step();
            check("en_issue", o_en, oh);
            check("in1_issue", o_in1, a);
            check("in2_issue", o_in2, b);
            check("ov_issue", o_ov, 0);
            check("rdy_issue", o_rdy, 0);
            check("busy_issue", o_busy, 1);
        end
        step();                               // capture edge E+s
        check("en_after_capture", o_en, 0);
        check("ov_capture", o_ov, 1);
        check("res_capture", o_res, exp);
        check("zero_capture", o_oz, exp == 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                in_valid = h[0];
                in_a     = ~a;
                in_b     = a;
            end
            step();
            check("ov_hold", o_ov, 1);
            check("res_hold", o_res, exp);
            check("rdy_hold", o_rdy, 0);
            check("in1_hold", o_in1, a);
            check("en_hold", o_en, 0);
        end
        in_valid  = keep;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        step();                               // handshake edge
        check("ov_done", o_ov, 0);
        check("rdy_done", o_rdy, 1);
        check("busy_done", o_busy, 0);
        check("res_kept", o_res, exp);
        check("in1_kept", o_in1, a);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          diff;
        Rst       = 1'b1;
        in_valid  = 1'b0;
        cur_sel   = 1'b0;
        in_op     = 2'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", rdy0, 1);
        check("rst_en", en0, 0);
        check("rst_ov", ov0, 0);
        check("rst_busy", busy0, 0);
        check("rst_zero", oz0, 1);
        check("rst_in1", in1_0, 0);
        check("rst_in2", in2_0, 0);
        check("rst_res", ores0, 0);
        check("rst_en_s1", en1, 0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        do_op(1'b0, 2'd0, 32'hF0F0_1234, 32'hFF00_00FF, 0, 1'b0, 1'b0);
        do_op(1'b0, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 1'b1, 1'b0);

        do_op(1'b0, 2'd3, 32'h0, 32'h0, 0, 1'b0, 1'b1);
        do_op(1'b0, 2'd1, 32'h1, 32'h8, 0, 1'b0, 1'b0);
        diff = (acc0.size() >= 2) ? (acc0[acc0.size()-1] - acc0[acc0.size()-2]) : -1;
        check("b2b_interval", diff, 4);

        // Reset during the second ISSUE cycle.
        cur_sel  = 1'b0;
        in_op    = 2'd1;
        in_a     = 32'h1234_5678;
        in_b     = 32'h0F0F_0F0F;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("midrst_en_before", en0, 4'b0010);
        Rst = 1'b1;
        #1;
        check("midrst_en", en0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_ov", ov0, 0);
        check("midrst_rdy", rdy0, 1);
        check("midrst_res", ores0, 0);
        check("midrst_zero", oz0, 1);
        check("midrst_in1", in1_0, 0);
        step();
        Rst = 1'b0;
        do_op(1'b0, 2'd2, 32'hA5A5_0000, 32'h0000_5A5A, 1, 1'b0, 1'b0);

        do_op(1'b1, 2'd0, 32'hFFFF_FFFF, 32'h5555_5555, 0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, rb,
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
